// File: rtl/cbfp_denorm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cbfp_denorm_serializer
// Purpose  : Buffers one 16-lane CBFP block, restores each lane to the wide
//            fixed-point domain and serializes it under valid/ready.
//            Optional rounding build: define CBFP_DENORM_ROUND_EN.
// Revision : 1.0  initial release
// ============================================================================
module cbfp_denorm_serializer #(
   parameter int DATA_W     = 12,
   parameter int IDX_W      = 5,
   parameter int LANES      = 16,
   parameter int FRAC_SHIFT = 13,
   parameter int OUT_W      = 25,
   localparam int CNT_W     = $clog2(LANES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic signed [DATA_W-1:0] din_i    [0:LANES-1],
   input  logic signed [DATA_W-1:0] din_q    [0:LANES-1],
   input  logic        [IDX_W-1:0]  index_re [0:LANES-1],
   input  logic        [IDX_W-1:0]  index_im [0:LANES-1],
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic signed [OUT_W-1:0]  dout_i,
   output logic signed [OUT_W-1:0]  dout_q,
   output logic        [CNT_W-1:0]  dout_lane,
   output logic                     dout_last
);

   localparam int WIDE_W = OUT_W + 32;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic signed [DATA_W-1:0] buf_i  [0:LANES-1];
   logic signed [DATA_W-1:0] buf_q  [0:LANES-1];
   logic        [IDX_W-1:0]  buf_re [0:LANES-1];
   logic        [IDX_W-1:0]  buf_im [0:LANES-1];

   logic accept;
   logic at_last;

   // Sign-extend, scale up, then arithmetic right shift by the block index.
   function automatic logic signed [OUT_W-1:0] restore(
      input logic signed [DATA_W-1:0] d,
      input logic        [IDX_W-1:0]  idx
   );
      logic signed [WIDE_W-1:0] x;
      x = {{(WIDE_W-DATA_W){d[DATA_W-1]}}, d};
      x = x <<< FRAC_SHIFT;
`ifdef CBFP_DENORM_ROUND_EN
      if (idx != '0)
         x = x + (WIDE_W'(1) << (idx - IDX_W'(1)));
`endif
      x = x >>> idx;
      return x[OUT_W-1:0];
   endfunction

   assign at_last   = (cnt == LAST_LANE);
   assign din_ready = (state == IDLE) || (at_last && dout_ready);
   assign accept    = din_valid && din_ready;

   assign dout_valid = (state == DRAIN);
   assign dout_lane  = cnt;
   assign dout_last  = dout_valid && at_last;
   assign dout_i     = dout_valid ? restore(buf_i[cnt], buf_re[cnt]) : '0;
   assign dout_q     = dout_valid ? restore(buf_q[cnt], buf_im[cnt]) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         for (int k = 0; k < LANES; k++) begin
            buf_i[k]  <= '0;
            buf_q[k]  <= '0;
            buf_re[k] <= '0;
            buf_im[k] <= '0;
         end
      end else if (accept) begin
         // Also covers the lane-(LANES-1) handshake overlapping a new block.
         state <= DRAIN;
         cnt   <= '0;
         for (int k = 0; k < LANES; k++) begin
            buf_i[k]  <= din_i[k];
            buf_q[k]  <= din_q[k];
            buf_re[k] <= index_re[k];
            buf_im[k] <= index_im[k];
         end
      end else if (state == DRAIN && dout_ready) begin
         cnt <= cnt + CNT_W'(1);
         if (at_last)
            state <= IDLE;
      end
   end

endmodule
`default_nettype wire
